// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-pipeline definitions used by the writeback arbiter:
//   wb_entry_t      one buffered writeback {dest, result}
//   WB_SRC_*        requester indices into the arbiter's source vectors
//   WB_NUM_SRC      number of writeback requesters
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] result;
    } wb_entry_t;

    localparam int unsigned WB_SRC_DCACHE = 0;
    localparam int unsigned WB_SRC_AUX    = 1;
    localparam int unsigned WB_SRC_FPU    = 2;
    localparam int unsigned WB_SRC_DIV    = 3;
    localparam int unsigned WB_NUM_SRC    = 4;

endpackage

// File: rtl/cpu_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// cpu_wb_arbiter_if
// Bundles the requester-side valid/ready handshakes and the combine-stage
// writeback port of cpu_wb_arbiter.
//   src_valid/src_dest/src_data -> arbiter, src_ready <- arbiter
//   wb_ready -> arbiter, wb_valid/wb_dest/wb_result/wb_count <- arbiter
// Modports:
//   slave  : the arbiter
//   master : requesters plus combine stage (testbench side)
// ----------------------------------------------------------------------------
interface cpu_wb_arbiter_if #(
    parameter int unsigned NUM_SRC = 4
);

    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC-1:0][4:0]  src_dest;
    logic [NUM_SRC-1:0][31:0] src_data;
    logic [NUM_SRC-1:0]       src_ready;

    logic                     wb_ready;
    logic                     wb_valid;
    logic [4:0]               wb_dest;
    logic [31:0]              wb_result;
    logic [1:0]               wb_count;

    modport slave (
        input  src_valid, src_dest, src_data, wb_ready,
        output src_ready, wb_valid, wb_dest, wb_result, wb_count
    );

    modport master (
        output src_valid, src_dest, src_data, wb_ready,
        input  src_ready, wb_valid, wb_dest, wb_result, wb_count
    );

endinterface

// File: rtl/cpu_wb_fifo2.sv
// ----------------------------------------------------------------------------
// cpu_wb_fifo2
// Two-entry FIFO of wb_entry_t. entry0 is always the head, so the head output
// comes straight from a register. Entries are cleared when they leave, so an
// empty FIFO presents an all-zero head.
// Ports:
//   clock, reset   clock, synchronous active-high reset
//   push_i         write push_data_i at the tail
//   push_data_i    entry to write
//   pop_i          drop the head (caller guarantees count_o != 0)
//   head_o         head entry
//   count_o        occupancy 0..2
// ----------------------------------------------------------------------------
module cpu_wb_fifo2
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  wb_entry_t  push_data_i,
    input  logic       pop_i,
    output wb_entry_t  head_o,
    output logic [1:0] count_o
);

    wb_entry_t  entry0_q, entry0_d;
    wb_entry_t  entry1_q, entry1_d;
    logic [1:0] count_q,  count_d;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    entry0_d = push_data_i;
                end else begin
                    entry1_d = push_data_i;
                end
            end
            2'b01: begin
                count_d  = count_q - 2'd1;
                entry0_d = entry1_q;
                entry1_d = '0;
            end
            2'b11: begin
                // Count unchanged: the new entry lands where the shifted-out
                // slot used to be.
                if (count_q == 2'd2) begin
                    entry0_d = entry1_q;
                    entry1_d = push_data_i;
                end else if (count_q == 2'd1) begin
                    entry0_d = push_data_i;
                end else begin
                    entry0_d = push_data_i;
                    count_d  = 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = entry0_q;
    assign count_o = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && push_i && !pop_i && count_q == 2'd2) begin
            $display("cpu_wb_fifo2: push into full buffer");
            $stop;
        end
    end
`endif

endmodule

// File: rtl/cpu_wb_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_wb_arbiter
// Shares the single writeback port into the combine stage between dcache,
// aux-bus, FPU and divider results. Each requester is back-pressured through
// valid/ready; granted results go through a 2-entry buffer so wb_ready never
// reaches src_ready combinationally.
// Ports:
//   clock, reset   clock, synchronous active-high reset
//   bus (slave)    src_valid/src_dest/src_data/src_ready per requester,
//                  wb_ready/wb_valid/wb_dest/wb_result/wb_count to combine
// Parameters:
//   NUM_SRC        number of requesters (0 dcache, 1 aux, 2 FPU, 3 divider)
//   DEPTH          output buffer entries; only 2 is supported
// Configuration:
//   CPU_WBARB_RR_EN defined   round-robin priority via rr_ptr
//   CPU_WBARB_RR_EN undefined fixed priority, lowest index wins
// Requests with dest 0 are discards: always accepted outside reset, never
// buffered, and they do not affect priority.
// ----------------------------------------------------------------------------
module cpu_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_SRC = WB_NUM_SRC,
    parameter int unsigned DEPTH   = 2
) (
    input logic             clock,
    input logic             reset,
    cpu_wb_arbiter_if.slave bus
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [NUM_SRC-1:0] req_nz;
    logic [NUM_SRC-1:0] discard;
    logic [NUM_SRC-1:0] grant;
    logic               can_grant;
    logic               found;
    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic [1:0]         count;
    logic               push;
    logic               pop;

    always_comb begin
        req_nz  = '0;
        discard = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            req_nz[i]  = bus.src_valid[i] && (bus.src_dest[i] != 5'd0);
            discard[i] = bus.src_valid[i] && (bus.src_dest[i] == 5'd0);
        end
    end

    // Uses registered count only, keeping wb_ready off the src_ready path.
    assign can_grant = !reset && (count != FULL_CNT);

`ifdef CPU_WBARB_RR_EN
    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] gnt_idx;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        idx     = '0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!found && can_grant && req_nz[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
        rr_ptr_d = found ? PTR_W'((32'(gnt_idx) + 32'd1) % NUM_SRC) : rr_ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found && can_grant && req_nz[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        push_entry = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                push_entry.dest   = bus.src_dest[i];
                push_entry.result = bus.src_data[i];
            end
        end
    end

    assign bus.src_ready = grant | (discard & {NUM_SRC{!reset}});

    assign push = |grant;
    assign pop  = bus.wb_valid && bus.wb_ready;

    cpu_wb_fifo2 u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.wb_valid  = (count != 2'd0);
    assign bus.wb_dest   = bus.wb_valid ? head.dest   : 5'd0;
    assign bus.wb_result = bus.wb_valid ? head.result : 32'd0;
    assign bus.wb_count  = count;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && $countones(grant) > 1) begin
            $display("cpu_wb_arbiter: multiple grants 0x%h", grant);
            $stop;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_wb_arbiter
// Directed stimulus for cpu_wb_arbiter. Expected writebacks are queued as the
// stimulus issues them; a monitor pops and compares on every wb handshake.
// Handshake-side expectations (src_ready, wb_count) are checked inline.
// ----------------------------------------------------------------------------
module tb_cpu_wb_arbiter;
    import cpu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    cpu_wb_arbiter_if #(.NUM_SRC(WB_NUM_SRC)) bus ();

    cpu_wb_arbiter #(
        .NUM_SRC (WB_NUM_SRC),
        .DEPTH   (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int        vectors     = 0;
    int        miscompares = 0;
    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    // rr_ptr after the two dcache grants that precede the round-robin test
    localparam int unsigned RR_START = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic set_src(input int unsigned i, input logic v, input logic [4:0] d, input logic [31:0] x);
        bus.src_valid[i] = v;
        bus.src_dest[i]  = d;
        bus.src_data[i]  = x;
    endtask

    task automatic expect_wb(input logic [4:0] d, input logic [31:0] x);
        exp_q.push_back(wb_entry_t'{dest: d, result: x});
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset && bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wb: got dest %0d result 0x%h, expected no writeback",
                         bus.wb_dest, bus.wb_result);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_dest", 32'(bus.wb_dest), 32'(mon_e.dest));
                check("wb_result", bus.wb_result, mon_e.result);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned g;

        bus.src_valid = '0;
        bus.src_dest  = '0;
        bus.src_data  = '0;
        bus.wb_ready  = 1'b1;
        reset         = 1'b1;

        // Reset with every requester valid
        for (int unsigned i = 0; i < 4; i++) set_src(i, 1'b1, 5'(i + 1), 32'hA000_0000 + i);
        next_cycle();
        repeat (3) begin
            @(negedge clock);
            check("rst_src_ready", 32'(bus.src_ready), 32'h0);
            check("rst_wb_valid",  32'(bus.wb_valid),  32'h0);
            check("rst_wb_dest",   32'(bus.wb_dest),   32'h0);
            check("rst_wb_count",  32'(bus.wb_count),  32'h0);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clock);
        check("first_grant", 32'(bus.src_ready), 32'h1);
        expect_wb(5'd1, 32'hA000_0000);
        next_cycle();
        bus.src_valid = '0;
        @(negedge clock);
        check("first_count", 32'(bus.wb_count), 32'd1);
        next_cycle();

        // Single source: dcache, dest 5
        set_src(WB_SRC_DCACHE, 1'b1, 5'd5, 32'hFFFF_FF80);
        @(negedge clock);
        check("single_ready", 32'(bus.src_ready), 32'h1);
        expect_wb(5'd5, 32'hFFFF_FF80);
        next_cycle();
        set_src(WB_SRC_DCACHE, 1'b0, 5'd0, 32'h0);
        @(negedge clock);
        check("single_valid",  32'(bus.wb_valid), 32'h1);
        check("single_dest",   32'(bus.wb_dest),  32'd5);
        check("single_result", bus.wb_result,     32'hFFFF_FF80);
        check("single_count",  32'(bus.wb_count), 32'd1);
        next_cycle();
        @(negedge clock);
        check("idle_count", 32'(bus.wb_count), 32'd0);
        check("idle_dest",  32'(bus.wb_dest),  32'd0);
        next_cycle();

        // All four sources continuously valid, wb_ready = 1
        for (int unsigned i = 0; i < 4; i++) set_src(i, 1'b1, 5'(i + 1), 32'hC000_0000 + 32'(i * 16));
        for (int unsigned c = 0; c < 8; c++) begin
`ifdef CPU_WBARB_RR_EN
            g = (RR_START + c) % 4;
`else
            g = 0;
`endif
            @(negedge clock);
            check("rr_grant", 32'(bus.src_ready), 32'(1) << g);
            check("rr_count", 32'(bus.wb_count), (c == 0) ? 32'd0 : 32'd1);
            expect_wb(5'(g + 1), 32'hC000_0000 + 32'(g * 16));
            next_cycle();
        end
        bus.src_valid = '0;
        @(negedge clock);
        check("rr_drain1", 32'(bus.wb_count), 32'd1);
        next_cycle();
        @(negedge clock);
        check("rr_drain0", 32'(bus.wb_count), 32'd0);
        next_cycle();

        // Back-pressure with FPU and divider, plus r0 discard while full
        bus.wb_ready = 1'b0;
        set_src(WB_SRC_FPU, 1'b1, 5'd7, 32'h3F80_0000);
        set_src(WB_SRC_DIV, 1'b1, 5'd9, 32'h0000_0007);
        @(negedge clock);
        check("bp_grant_a", 32'(bus.src_ready), 32'b0100);
        expect_wb(5'd7, 32'h3F80_0000);
        next_cycle();
        set_src(WB_SRC_FPU, 1'b0, 5'd0, 32'h0);
        @(negedge clock);
        check("bp_grant_b", 32'(bus.src_ready), 32'b1000);
        check("bp_count_b", 32'(bus.wb_count), 32'd1);
        expect_wb(5'd9, 32'h0000_0007);
        next_cycle();
        set_src(WB_SRC_DIV, 1'b0, 5'd0, 32'h0);
        set_src(WB_SRC_FPU, 1'b1, 5'd10, 32'h4049_0FDB);
        set_src(WB_SRC_AUX, 1'b1, 5'd0, 32'hDEAD_BEEF);
        @(negedge clock);
        check("r0_ready",     32'(bus.src_ready), 32'b0010);
        check("full_count_c", 32'(bus.wb_count),  32'd2);
        check("full_dest_c",  32'(bus.wb_dest),   32'd7);
        next_cycle();
        set_src(WB_SRC_AUX, 1'b0, 5'd0, 32'h0);
        @(negedge clock);
        check("full_stall",   32'(bus.src_ready), 32'b0000);
        check("full_count_d", 32'(bus.wb_count),  32'd2);
        check("full_dest_d",  32'(bus.wb_dest),   32'd7);
        next_cycle();
        bus.wb_ready = 1'b1;
        @(negedge clock);
        check("pop_no_grant", 32'(bus.src_ready), 32'b0000);
        check("pop_count_e",  32'(bus.wb_count),  32'd2);
        next_cycle();
        @(negedge clock);
        check("after_pop_grant", 32'(bus.src_ready), 32'b0100);
        check("after_pop_count", 32'(bus.wb_count),  32'd1);
        check("after_pop_dest",  32'(bus.wb_dest),   32'd9);
        expect_wb(5'd10, 32'h4049_0FDB);
        next_cycle();
        set_src(WB_SRC_FPU, 1'b0, 5'd0, 32'h0);
        @(negedge clock);
        check("bp_count_g", 32'(bus.wb_count), 32'd1);
        check("bp_dest_g",  32'(bus.wb_dest),  32'd10);
        next_cycle();
        @(negedge clock);
        check("bp_count_h", 32'(bus.wb_count), 32'd0);
        next_cycle();

        // Reset mid-flight with a full buffer; these entries are never expected
        bus.wb_ready = 1'b0;
        set_src(WB_SRC_DCACHE, 1'b1, 5'd11, 32'h0000_0111);
        @(negedge clock);
        check("mid_grant0", 32'(bus.src_ready), 32'b0001);
        next_cycle();
        set_src(WB_SRC_DCACHE, 1'b0, 5'd0, 32'h0);
        set_src(WB_SRC_AUX, 1'b1, 5'd12, 32'h0000_0222);
        @(negedge clock);
        check("mid_grant1", 32'(bus.src_ready), 32'b0010);
        next_cycle();
        set_src(WB_SRC_AUX, 1'b0, 5'd0, 32'h0);
        @(negedge clock);
        check("mid_full", 32'(bus.wb_count), 32'd2);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset        = 1'b0;
        bus.wb_ready = 1'b1;
        @(negedge clock);
        check("mid_valid", 32'(bus.wb_valid), 32'h0);
        check("mid_count", 32'(bus.wb_count), 32'd0);
        check("mid_dest",  32'(bus.wb_dest),  32'd0);
        next_cycle();
        repeat (3) begin
            @(negedge clock);
            check("mid_quiet", 32'(bus.wb_valid), 32'h0);
            next_cycle();
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
